// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
//   mem_op_t   : load/store opcode carried on req_op
//   state_t    : access FSM states
//   is_store   : true for SW/SH/SB
//   is_aligned : alignment rule for an opcode and byte offset
package mem_access_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        MERGE
    } state_t;

    function automatic logic is_store(mem_op_t op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    function automatic logic is_aligned(mem_op_t op, logic [1:0] offset);
        case (op)
            LW, SW:       return offset == 2'b00;
            LH, LHU, SH:  return offset[0] == 1'b0;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response handshake between the memory-stage control and the access unit.
//   master : requester (drives req_valid/op/addr/wdata, sees ready and responses)
//   slave  : mem_access_unit
interface mem_access_if #(
    parameter int unsigned ADDR_W = 10
);
    import mem_access_pkg::*;

    logic               req_valid;
    logic               req_ready;
    mem_op_t            req_op;
    logic [ADDR_W+1:0]  req_addr;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic [31:0]        resp_rdata;
    logic               resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for sub-word accesses (little-endian).
//   op       : access opcode
//   offset   : byte offset within the word (addr[1:0])
//   word     : word read from memory
//   wdata    : right-aligned store data
//   load_val : selected lane, sign/zero extended to 32 bits
//   merged   : word with the addressed byte/halfword lane replaced by wdata
module mem_lane_align
    import mem_access_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Halfword accesses are only issued when offset[0] is clear.
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = word;
        case (op)
            LB:      load_val = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_val = {24'h0, byte_sel};
            LH:      load_val = {{16{half_sel[15]}}, half_sel};
            LHU:     load_val = {16'h0, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
        merged = word;
        if (op == SB) begin
            case (offset)
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
                default: merged = word;
            endcase
        end else if (op == SH) begin
            if (offset[1]) merged[31:16] = wdata[15:0];
            else           merged[15:0]  = wdata[15:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the word-addressed data memory. Accepts byte-addressed
// LW/LH/LHU/LB/LBU/SW/SH/SB requests, extends loads, read-modify-writes
// sub-word stores and flags misaligned accesses.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : request/response handshake (slave side)
//   mem_w_en   : data memory write enable
//   mem_addr   : data memory word address
//   mem_d_in   : data memory write data
//   mem_d_out  : data memory read data (word at the previous cycle's mem_addr)
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_if.slave       bus,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_d_in,
    input  logic [31:0]       mem_d_out
);

    state_t             state_q;
    mem_op_t            op_q;
    logic [1:0]         offset_q;
    logic [31:0]        wdata_q;
    logic               w_en_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        d_in_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    logic [31:0]        load_val;
    logic [31:0]        merged_word;

    mem_lane_align u_lane_align (
        .op       (op_q),
        .offset   (offset_q),
        .word     (mem_d_out),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged_word)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign mem_w_en = w_en_q;
    assign mem_addr = addr_q;
    // The read word only arrives during MERGE, so the merged data bypasses
    // the register to let the write land in that same cycle.
    assign mem_d_in = (state_q == MERGE) ? merged_word : d_in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= LW;
            offset_q     <= 2'b00;
            wdata_q      <= 32'h0;
            w_en_q       <= 1'b0;
            addr_q       <= '0;
            d_in_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (!is_aligned(bus.req_op, bus.req_addr[1:0])) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            op_q     <= bus.req_op;
                            offset_q <= bus.req_addr[1:0];
                            wdata_q  <= bus.req_wdata;
                            addr_q   <= bus.req_addr[ADDR_W+1:2];
                            d_in_q   <= bus.req_wdata;
                            w_en_q   <= (bus.req_op == SW);
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    case (op_q)
                        SW: begin
                            w_en_q       <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_err_q   <= 1'b0;
                            state_q      <= IDLE;
                        end
                        SH, SB: begin
                            w_en_q  <= 1'b1;
                            state_q <= MERGE;
                        end
                        default: state_q <= CAPTURE;
                    endcase
                end
                CAPTURE: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_val;
                    resp_err_q   <= 1'b0;
                    state_q      <= IDLE;
                end
                MERGE: begin
                    w_en_q       <= 1'b0;
                    d_in_q       <= merged_word;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural word memory, directed scenarios and
// randomized requests checked against a byte-level reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(ADDR_W)) bus ();

    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_d_in;
    logic [31:0]       mem_d_out;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_w_en  (mem_w_en),
        .mem_addr  (mem_addr),
        .mem_d_in  (mem_d_in),
        .mem_d_out (mem_d_out)
    );

    // Synchronous-read data memory; ref_mem is the expected image.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        load_mem = 1'b1;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= ref_mem[i];
        end else if (mem_w_en) begin
            mem[mem_addr] <= mem_d_in;
        end
        mem_d_out <= mem[mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model, written directly from the byte-lane rules.
    function automatic bit ref_aligned(mem_op_t op, int addr);
        if (op == LW || op == SW) return (addr % 4) == 0;
        if (op == LH || op == LHU || op == SH) return (addr % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(mem_op_t op, logic [31:0] w, int off);
        int b;
        int h;
        b = int'((w >> (8 * off)) & 32'hFF);
        h = int'((w >> (8 * off)) & 32'hFFFF);
        case (op)
            LB:  return (b < 128) ? 32'(b) : 32'(b - 256);
            LBU: return 32'(b);
            LH:  return (h < 32768) ? 32'(h) : 32'(h - 65536);
            LHU: return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(mem_op_t op, logic [31:0] w, int off,
                                              logic [31:0] wd);
        logic [31:0] m;
        logic [31:0] d;
        m = (op == SH) ? 32'h0000_FFFF : 32'h0000_00FF;
        d = wd & m;
        return (w & ~(m << (8 * off))) | (d << (8 * off));
    endfunction

    // Starts at a negedge with the unit idle; returns at the negedge where
    // resp_valid is seen (or after the cycle budget expires).
    task automatic do_req(input mem_op_t op, input logic [ADDR_W+1:0] addr,
                          input logic [31:0] wdata, input string name);
        int          word;
        int          off;
        int          exp_lat;
        int          exp_wr;
        int          exp_wr_cyc;
        logic [31:0] exp_wr_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          wr_n;
        int          wr_c;
        logic [31:0] wr_d;
        logic [31:0] wr_a;
        bit          done;

        word        = int'(addr) / 4;
        off         = int'(addr) % 4;
        exp_wr      = 0;
        exp_wr_cyc  = 0;
        exp_wr_data = 32'h0;
        exp_rdata   = 32'h0;
        exp_err     = 1'b0;
        if (!ref_aligned(op, int'(addr))) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else if (op == SW) begin
            exp_lat      = 2;
            exp_wr       = 1;
            exp_wr_cyc   = 1;
            exp_wr_data  = wdata;
            ref_mem[word] = wdata;
        end else if (op == SH || op == SB) begin
            exp_lat      = 3;
            exp_wr       = 1;
            exp_wr_cyc   = 2;
            exp_wr_data  = ref_merge(op, ref_mem[word], off, wdata);
            ref_mem[word] = exp_wr_data;
        end else begin
            exp_lat   = 3;
            exp_rdata = ref_load(op, ref_mem[word], off);
        end

        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        check_eq({name, " ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request lines to show they are ignored after acceptance.
        bus.req_valid = 1'b0;
        bus.req_op    = mem_op_t'($urandom_range(0, 7));
        bus.req_addr  = (ADDR_W + 2)'($urandom);
        bus.req_wdata = $urandom;

        lat  = 0;
        wr_n = 0;
        wr_c = 0;
        wr_d = 32'h0;
        wr_a = 32'h0;
        done = 1'b0;
        for (int c = 1; c <= 6 && !done; c++) begin
            @(negedge clk);
            if (mem_w_en) begin
                wr_n++;
                wr_c = c;
                wr_d = mem_d_in;
                wr_a = 32'(mem_addr);
            end
            if (bus.resp_valid) begin
                lat  = c;
                done = 1'b1;
            end
        end

        check_eq({name, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({name, " resp_err"}, 32'(bus.resp_err), 32'(exp_err));
        check_eq({name, " resp_rdata"}, bus.resp_rdata, exp_rdata);
        check_eq({name, " write count"}, 32'(wr_n), 32'(exp_wr));
        if (exp_wr != 0) begin
            check_eq({name, " write cycle"}, 32'(wr_c), 32'(exp_wr_cyc));
            check_eq({name, " write data"}, wr_d, exp_wr_data);
            check_eq({name, " write addr"}, wr_a, 32'(word));
        end
    endtask

    task automatic check_word(input int idx);
        check_eq($sformatf("mem word %0d", idx), mem[idx], ref_mem[idx]);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = LW;
        bus.req_addr  = '0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'h8081_82F3;
        ref_mem[2] = 32'h1111_2222;

        load_mem = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        load_mem = 1'b0;

        check_eq("reset req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("reset resp_rdata", bus.resp_rdata, 32'h0);
        check_eq("reset resp_err", 32'(bus.resp_err), 32'd0);
        check_eq("reset mem_w_en", 32'(mem_w_en), 32'd0);
        check_eq("reset mem_addr", 32'(mem_addr), 32'd0);
        check_eq("reset mem_d_in", mem_d_in, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back loads on word 1.
        do_req(LB,  12'h004, 32'h0, "LB 004");
        check_eq("LB 004 value", bus.resp_rdata, 32'hFFFF_FFF3);
        do_req(LBU, 12'h007, 32'h0, "LBU 007");
        check_eq("LBU 007 value", bus.resp_rdata, 32'h0000_0080);
        do_req(LH,  12'h006, 32'h0, "LH 006");
        check_eq("LH 006 value", bus.resp_rdata, 32'hFFFF_8081);
        do_req(LHU, 12'h004, 32'h0, "LHU 004");
        check_eq("LHU 004 value", bus.resp_rdata, 32'h0000_82F3);
        do_req(LW,  12'h004, 32'h0, "LW 004");
        check_eq("LW 004 value", bus.resp_rdata, 32'h8081_82F3);

        // Sub-word stores and full-word store.
        do_req(SB,  12'h005, 32'h1234_56AA, "SB 005");
        do_req(LW,  12'h004, 32'h0, "LW 004 after SB");
        check_eq("SB merged word", bus.resp_rdata, 32'h8081_AAF3);
        do_req(SH,  12'h00A, 32'h0000_BEEF, "SH 00A");
        check_eq("SH merged word", ref_mem[2], 32'hBEEF_2222);
        do_req(LW,  12'h008, 32'h0, "LW 008 after SH");
        do_req(SW,  12'h00C, 32'hDEAD_BEEF, "SW 00C");

        // Misaligned requests.
        do_req(SW,  12'h006, 32'h5555_AAAA, "SW 006 misaligned");
        do_req(LH,  12'h005, 32'h0, "LH 005 misaligned");
        do_req(LW,  12'h004, 32'h0, "LW 004 after errors");
        check_word(1);
        check_word(2);
        check_word(3);

        // Reset in the middle of an SB read-modify-write.
        bus.req_valid = 1'b1;
        bus.req_op    = SB;
        bus.req_addr  = 12'h004;
        bus.req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid-op rst mem_w_en", 32'(mem_w_en), 32'd0);
        check_eq("mid-op rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("mid-op rst req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check_eq("mid-op rst mem_w_en hold", 32'(mem_w_en), 32'd0);
        check_eq("mid-op rst resp_valid hold", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check_word(1);

        // Randomized requests, mostly over a small window to force reuse.
        for (int n = 0; n < 300; n++) begin
            mem_op_t          op;
            logic [ADDR_W+1:0] a;
            op = mem_op_t'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = (ADDR_W + 2)'($urandom);
            else                           a = (ADDR_W + 2)'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            do_req(op, a, $urandom, $sformatf("rnd%0d op%0d a%03h", n, op, a));
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++) check_word(i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data memory interface, placed between the memory-stage control and data_memory.
- Accepts byte-addressed load/store requests: LW, LH, LHU, LB, LBU, SW, SH, SB.
- Drives the memory's write enable, word address and write data, and captures its one-cycle synchronous read data.
- Performs sign/zero extension on loads and read-modify-write on sub-word stores; flags misaligned accesses.

Parameters:
- ADDR_W, 10, word-address width of the data memory. The byte address is ADDR_W+2 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit idle and able to accept a request
- req_op  input  3  mem_op_t opcode
- req_addr  input  ADDR_W+2  byte address
- req_wdata  input  32  store data; sub-word data is right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load result; 0 for stores and errors
- resp_err  output  1  misaligned access, qualified by resp_valid
- mem_w_en  output  1  to data memory write enable
- mem_addr  output  ADDR_W  to data memory word address
- mem_d_in  output  32  to data memory write data
- mem_d_out  input  32  from data memory; holds the word at the previous cycle's mem_addr

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_w_en=0, mem_addr=0, mem_d_in=0.
- Byte order: little-endian.
  - Byte offset k occupies bits 8k+7:8k.
  - Halfword offset 0 occupies bits 15:0; offset 2 occupies bits 31:16.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - req_ready = (state==IDLE), combinational from state.
  - At acceptance, op, addr and wdata are registered; request inputs are ignored afterwards.
- Alignment:
  - LW/SW require addr[1:0]==0.
  - LH/LHU/SH require addr[0]==0.
  - Byte accesses are always aligned.
- FSM states (state_t):
  - IDLE:
    - On an accepted misaligned request: resp_valid=1, resp_err=1, resp_rdata=0 next cycle; stay in IDLE; no memory access.
    - On an accepted aligned request: go to ISSUE.
  - ISSUE:
    - mem_addr = registered addr[ADDR_W+1:2].
    - For SW: mem_w_en=1, mem_d_in=wdata, then return to IDLE with resp_valid pulsed.
    - For loads: mem_w_en=0, go to CAPTURE.
    - For SH/SB: mem_w_en=0, go to MERGE.
  - CAPTURE:
    - Select the byte/halfword/word from mem_d_out using addr[1:0].
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - Register the result into resp_rdata and pulse resp_valid; return to IDLE.
  - MERGE:
    - mem_addr is held and mem_w_en=1.
    - mem_d_in = mem_d_out with the addressed lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH).
    - Pulse resp_valid; return to IDLE.
- Latency, counted from the acceptance edge as cycle 0:
  - error: response in cycle 1
  - SW: write in cycle 1, response in cycle 2
  - loads and SH/SB: response in cycle 3
- Output timing:
  - Memory-side outputs are registered, so values listed under a state are present during that state.
  - mem_w_en is never asserted in IDLE or CAPTURE.
  - resp_valid is a registered single-cycle pulse that coincides with IDLE. A new request may be accepted in the same cycle as resp_valid.
- Data hold: resp_rdata and resp_err hold their last value until the next response. Store responses clear both to 0.
- Reset mid-operation: any state returns to IDLE with no write and no resp_valid. An in-flight read-modify-write is abandoned, leaving memory unmodified.
- No range checking is performed: the byte address exactly spans memory.

Decomposition:
- Package mem_access_pkg contains:
  - mem_op_t: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7
  - state_t: IDLE, ISSUE, CAPTURE, MERGE
  - helper functions is_store and is_aligned
- One sub-module, mem_lane_align, is purely combinational and serves both the CAPTURE and MERGE paths.
  - Inputs: op, offset, word, wdata.
  - Outputs: extended load value and merged store word.
- The FSM and registers remain in mem_access_unit.

Test Plan:
- Preload word 1 = 0x8081_82F3, then issue loads back-to-back, each accepted in the cycle of the prior resp_valid:
  - LB 0x004 -> resp_rdata 0xFFFF_FFF3, resp_err 0, resp_valid in cycle 3
  - LBU 0x007 -> 0x0000_0080
  - LH 0x006 -> 0xFFFF_8081
  - LHU 0x004 -> 0x0000_82F3
  - LW 0x004 -> 0x8081_82F3
- SB 0x005 with wdata 0x1234_56AA on word 1 -> single write of 0x8081_AAF3 in cycle 2, resp in cycle 3. A subsequent LW 0x004 returns 0x8081_AAF3.
- SH 0x00A with wdata 0x0000_BEEF on word 2 = 0x1111_2222 -> word 2 becomes 0xBEEF_2222.
- SW 0x00C with 0xDEAD_BEEF -> mem_w_en high in cycle 1 only, resp in cycle 2, resp_rdata 0.
- Misaligned requests:
  - SW 0x006 -> resp_err=1 in cycle 1, mem_w_en never asserted, word 1 unchanged.
  - LH 0x005 -> resp_err=1.
- Assert rst during MERGE of SB 0x004 -> mem_w_en stays 0, no resp_valid, req_ready=1 immediately, word 1 unchanged.
